// File: rtl/memory_unit_pkg.sv
// Shared types for memory_unit: memory_op encoding, FSM state enum and the default address width.
package memory_unit_pkg;

  localparam int ADDR_W_DEF = 16;

  typedef enum logic [2:0] {
    MEM_OP_NOP      = 3'd0,
    MEM_OP_READ     = 3'd1,
    MEM_OP_WRITE    = 3'd2,
    MEM_OP_FETCH    = 3'd3,
    MEM_OP_LOAD_PC  = 3'd4,
    MEM_OP_LOAD_MAR = 3'd5,
    MEM_OP_INC_PC   = 3'd6
  } memory_op_e;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_REQ  = 2'd1,
    MEM_ST_DONE = 2'd2
  } mem_state_e;

  function automatic logic is_access_op(input memory_op_e op);
    return (op == MEM_OP_READ) || (op == MEM_OP_WRITE) || (op == MEM_OP_FETCH);
  endfunction

endpackage

// File: rtl/memory_unit_if.sv
// External byte-wide RAM port: registered request/address/data out, one-cycle ack with read data back.
interface memory_unit_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] ext_addr;
  logic [7:0]        ext_wdata;
  logic              ext_we;
  logic              ext_req;
  logic              ext_ack;
  logic [7:0]        ext_rdata;

  modport master (
    output ext_addr, ext_wdata, ext_we, ext_req,
    input  ext_ack, ext_rdata
  );

  modport slave (
    input  ext_addr, ext_wdata, ext_we, ext_req,
    output ext_ack, ext_rdata
  );
endinterface

// File: rtl/memory_unit_addr_regs.sv
// PC and MAR with byte-wise loads and PC increment; muxes the access address (0 = PC, 1 = MAR).
module memory_unit_addr_regs #(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_pc,
  input  logic              load_mar,
  input  logic              byte_hi,
  input  logic [7:0]        bus_in,
  input  logic              inc_pc,
  input  logic              addr_sel,
  output logic [ADDR_W-1:0] access_addr
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;

  // Widen to 16 bits so the high-byte write works for any ADDR_W; bits above ADDR_W fall off.
  function automatic logic [ADDR_W-1:0] load_byte(input logic [ADDR_W-1:0] cur,
                                                  input logic hi, input logic [7:0] b);
    logic [15:0] w;
    w = 16'(cur);
    if (hi) w[15:8] = b;
    else    w[7:0]  = b;
    return w[ADDR_W-1:0];
  endfunction

  always_comb begin
    pc_d  = pc_q;
    mar_d = mar_q;
    if (load_pc)     pc_d  = load_byte(pc_q, byte_hi, bus_in);
    else if (inc_pc) pc_d  = pc_q + ADDR_W'(1);
    if (load_mar)    mar_d = load_byte(mar_q, byte_hi, bus_in);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= '0;
      mar_q <= '0;
    end else begin
      pc_q  <= pc_d;
      mar_q <= mar_d;
    end
  end

  assign access_addr = addr_sel ? mar_q : pc_q;

endmodule

// File: rtl/memory_unit.sv
// Runs control_unit memory ops against an external RAM: IDLE -> REQ -> DONE, stalling until the ack
// (or timeout), then presents read data on the bus for one cycle in DONE.
module memory_unit
  import memory_unit_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  memory_op_e    memory_op,
  input  logic          data_word_selector,
  input  logic          bus_selector,
  input  logic [7:0]    bus_in,
  output logic [7:0]    bus_out,
  output logic          bus_out_en,
  output logic          stall,
  output logic          mem_error,
  memory_unit_if.master ext
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              fetch_q, fetch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              load_pc, load_mar, inc_pc, addr_sel;
  logic [ADDR_W-1:0] access_addr;

  memory_unit_addr_regs #(.ADDR_W(ADDR_W)) u_addr_regs (
    .clock       (clock),
    .reset       (reset),
    .load_pc     (load_pc),
    .load_mar    (load_mar),
    .byte_hi     (data_word_selector),
    .bus_in      (bus_in),
    .inc_pc      (inc_pc),
    .addr_sel    (addr_sel),
    .access_addr (access_addr)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    fetch_d    = fetch_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    load_pc    = 1'b0;
    load_mar   = 1'b0;
    inc_pc     = 1'b0;
    addr_sel   = bus_selector && (memory_op != MEM_OP_FETCH);
    stall      = 1'b0;
    bus_out_en = 1'b0;
    bus_out    = 8'h00;

    case (state_q)
      MEM_ST_IDLE: begin
        if (is_access_op(memory_op)) begin
          stall   = 1'b1;
          state_d = MEM_ST_REQ;
          req_d   = 1'b1;
          we_d    = (memory_op == MEM_OP_WRITE);
          fetch_d = (memory_op == MEM_OP_FETCH);
          addr_d  = access_addr;
          wdata_d = bus_in;
          cnt_d   = '0;
        end else begin
          load_pc  = (memory_op == MEM_OP_LOAD_PC);
          load_mar = (memory_op == MEM_OP_LOAD_MAR);
          inc_pc   = (memory_op == MEM_OP_INC_PC);
        end
      end
      MEM_ST_REQ: begin
        stall = 1'b1;
        // Ack is checked first so an ack on the final allowed cycle still completes cleanly.
        if (ext.ext_ack) begin
          req_d   = 1'b0;
          rdata_d = ext.ext_rdata;
          inc_pc  = fetch_q;
          state_d = MEM_ST_DONE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = 8'hFF;
          state_d = MEM_ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MEM_ST_DONE: begin
        bus_out_en = !we_q;
        bus_out    = we_q ? 8'h00 : rdata_q;
        state_d    = MEM_ST_IDLE;
      end
      default: state_d = MEM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MEM_ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      fetch_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      fetch_q <= fetch_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign ext.ext_addr  = addr_q;
  assign ext.ext_wdata = wdata_q;
  assign ext.ext_we    = we_q;
  assign ext.ext_req   = req_q;
  assign mem_error     = err_q;

endmodule

// File: tb/tb_memory_unit.sv
// Bench for memory_unit: op table with a read-data scoreboard, plus reset-mid-access and spurious-ack sequences.
module tb_memory_unit;
  import memory_unit_pkg::*;

  localparam int TMO = 15;

  logic       clock = 1'b0;
  logic       reset;
  memory_op_e memory_op;
  logic       data_word_selector, bus_selector;
  logic [7:0] bus_in, bus_out;
  logic       bus_out_en, stall, mem_error;

  memory_unit_if #(.ADDR_W(16)) mif ();

  memory_unit #(.ADDR_W(16), .ACK_TIMEOUT(TMO)) dut (
    .clock              (clock),
    .reset              (reset),
    .memory_op          (memory_op),
    .data_word_selector (data_word_selector),
    .bus_selector       (bus_selector),
    .bus_in             (bus_in),
    .bus_out            (bus_out),
    .bus_out_en         (bus_out_en),
    .stall              (stall),
    .mem_error          (mem_error),
    .ext                (mif.master)
  );

  always #5 clock = ~clock;

  typedef struct {
    memory_op_e  op;
    logic        sel;
    logic        dsel;
    logic [7:0]  bin;
    int          ack_dly;   // REQ cycles before ack; -1 = never
    logic [7:0]  rdata;
    logic [15:0] exp_addr;
    logic        exp_err;
  } vec_t;

  vec_t       vecs[17];
  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   stall_cnt, waited, exp_wait;
    logic done;
    logic [7:0] exp_d;
    memory_op          = v.op;
    bus_selector       = v.sel;
    data_word_selector = v.dsel;
    bus_in             = v.bin;
    mif.ext_ack        = 1'b0;
    @(negedge clock);
    if (!is_access_op(v.op)) begin
      chk("single_stall", 32'(stall), 32'(0));
      chk("single_en", 32'(bus_out_en), 32'(0));
      chk("single_req", 32'(mif.ext_req), 32'(0));
      @(posedge clock); #1;
    end else begin
      if (v.op != MEM_OP_WRITE) exp_q.push_back((v.ack_dly < 0) ? 8'hFF : v.rdata);
      stall_cnt = stall ? 1 : 0;
      @(posedge clock); #1;
      chk("req_rise", 32'(mif.ext_req), 32'(1));
      chk("addr", 32'(mif.ext_addr), 32'(v.exp_addr));
      chk("we", 32'(mif.ext_we), 32'(v.op == MEM_OP_WRITE));
      if (v.op == MEM_OP_WRITE) chk("wdata", 32'(mif.ext_wdata), 32'(v.bin));
      waited = 0;
      done   = 1'b0;
      while (!done && waited < 40) begin
        mif.ext_ack   = (waited == v.ack_dly);
        mif.ext_rdata = mif.ext_ack ? v.rdata : 8'h5A;
        @(negedge clock);
        if (stall) stall_cnt++;
        chk("addr_hold", 32'(mif.ext_addr), 32'(v.exp_addr));
        @(posedge clock); #1;
        mif.ext_ack = 1'b0;
        waited++;
        if (!mif.ext_req) done = 1'b1;
      end
      exp_wait = (v.ack_dly >= 0) ? v.ack_dly + 1 : TMO;
      chk("req_cycles", 32'(waited), 32'(exp_wait));
      @(negedge clock);
      chk("done_stall", 32'(stall), 32'(0));
      chk("done_en", 32'(bus_out_en), 32'(v.op != MEM_OP_WRITE));
      if (bus_out_en) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'(1), 32'(0));
        end else begin
          exp_d = exp_q.pop_front();
          chk("bus_out", 32'(bus_out), 32'(exp_d));
        end
      end
      chk("stall_cycles", 32'(stall_cnt), 32'((v.ack_dly >= 0) ? v.ack_dly + 2 : TMO + 1));
      @(posedge clock); #1;
    end
    chk("mem_error", 32'(mem_error), 32'(v.exp_err));
  endtask

  initial begin
    vecs[0]  = '{MEM_OP_LOAD_PC,  1'b0, 1'b0, 8'h34, 0,  8'h00, 16'h0000, 1'b0};
    vecs[1]  = '{MEM_OP_LOAD_PC,  1'b0, 1'b1, 8'h12, 0,  8'h00, 16'h0000, 1'b0};
    vecs[2]  = '{MEM_OP_FETCH,    1'b1, 1'b0, 8'h00, 2,  8'hA5, 16'h1234, 1'b0};
    vecs[3]  = '{MEM_OP_FETCH,    1'b0, 1'b0, 8'h00, 0,  8'h3C, 16'h1235, 1'b0};
    vecs[4]  = '{MEM_OP_LOAD_MAR, 1'b0, 1'b0, 8'hF0, 0,  8'h00, 16'h0000, 1'b0};
    vecs[5]  = '{MEM_OP_LOAD_MAR, 1'b0, 1'b1, 8'h00, 0,  8'h00, 16'h0000, 1'b0};
    vecs[6]  = '{MEM_OP_WRITE,    1'b1, 1'b0, 8'h5C, 0,  8'h00, 16'h00F0, 1'b0};
    vecs[7]  = '{MEM_OP_READ,     1'b0, 1'b0, 8'h00, 1,  8'h77, 16'h1236, 1'b0};
    vecs[8]  = '{MEM_OP_LOAD_PC,  1'b0, 1'b0, 8'hFF, 0,  8'h00, 16'h0000, 1'b0};
    vecs[9]  = '{MEM_OP_LOAD_PC,  1'b0, 1'b1, 8'hFF, 0,  8'h00, 16'h0000, 1'b0};
    vecs[10] = '{MEM_OP_INC_PC,   1'b0, 1'b0, 8'h00, 0,  8'h00, 16'h0000, 1'b0};
    vecs[11] = '{MEM_OP_READ,     1'b0, 1'b0, 8'h00, 0,  8'h11, 16'h0000, 1'b0};
    vecs[12] = '{memory_op_e'(3'd7), 1'b0, 1'b0, 8'h99, 0, 8'h00, 16'h0000, 1'b0};
    vecs[13] = '{MEM_OP_READ,     1'b1, 1'b0, 8'h00, 0,  8'h22, 16'h00F0, 1'b0};
    vecs[14] = '{MEM_OP_READ,     1'b1, 1'b0, 8'h00, -1, 8'h00, 16'h00F0, 1'b1};
    vecs[15] = '{MEM_OP_READ,     1'b0, 1'b0, 8'h00, 0,  8'h99, 16'h0000, 1'b1};
    vecs[16] = '{MEM_OP_WRITE,    1'b0, 1'b0, 8'hC3, TMO - 1, 8'h00, 16'h0000, 1'b1};

    reset = 1'b1;
    memory_op = MEM_OP_NOP;
    data_word_selector = 1'b0;
    bus_selector = 1'b0;
    bus_in = 8'h00;
    mif.ext_ack = 1'b0;
    mif.ext_rdata = 8'h00;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_req", 32'(mif.ext_req), 32'(0));
    chk("rst_addr", 32'(mif.ext_addr), 32'(0));
    chk("rst_we", 32'(mif.ext_we), 32'(0));
    chk("rst_wdata", 32'(mif.ext_wdata), 32'(0));
    chk("rst_bus", 32'({bus_out_en, bus_out}), 32'(0));
    chk("rst_stall", 32'(stall), 32'(0));
    chk("rst_err", 32'(mem_error), 32'(0));
    @(posedge clock); #1;

    for (int i = 0; i < 17; i++) run_vec(vecs[i]);

    // Reset in the middle of an outstanding read, then a late ack.
    memory_op = MEM_OP_READ;
    bus_selector = 1'b1;
    @(posedge clock); #1;
    chk("mid_req", 32'(mif.ext_req), 32'(1));
    @(posedge clock); #1;
    reset = 1'b1;
    memory_op = MEM_OP_NOP;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("mid_rst_req", 32'(mif.ext_req), 32'(0));
    chk("mid_rst_stall", 32'(stall), 32'(0));
    chk("mid_rst_err", 32'(mem_error), 32'(0));
    mif.ext_ack = 1'b1;
    mif.ext_rdata = 8'hEE;
    @(posedge clock); #1;
    mif.ext_ack = 1'b0;
    @(negedge clock);
    chk("late_ack_en", 32'(bus_out_en), 32'(0));
    chk("late_ack_req", 32'(mif.ext_req), 32'(0));

    // Spurious acks in IDLE must not disturb anything.
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      mif.ext_ack = k[0];
      mif.ext_rdata = 8'h30 + 8'(k);
      @(negedge clock);
      chk("spur_stall", 32'(stall), 32'(0));
      chk("spur_en", 32'(bus_out_en), 32'(0));
      chk("spur_req", 32'(mif.ext_req), 32'(0));
    end
    @(posedge clock); #1;
    mif.ext_ack = 1'b0;
    begin
      vec_t post;
      post = '{MEM_OP_FETCH, 1'b0, 1'b0, 8'h00, 0, 8'h44, 16'h0000, 1'b0};
      run_vec(post);
      post = '{MEM_OP_FETCH, 1'b0, 1'b0, 8'h00, 3, 8'h45, 16'h0001, 1'b0};
      run_vec(post);
    end

    chk("sb_empty", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
